// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_unit: fetch FSM (one outstanding request) + 2-entry buffer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic [31:0] instruction,
  output logic [6:0]  instr_opcode,
  output logic [63:0] instr_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] DEPTH  = 2'(FIFO_DEPTH);

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, wr_ptr_q;
  logic [63:0] buf_pc_q    [2];
  logic [31:0] buf_instr_q [2];
  logic        push, pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (imem_req) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)       state_d = S_IDLE;
        else if (branch_taken) state_d = S_DROP;
      end
      S_DROP: if (imem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = !reset && (state_q == S_IDLE) && !branch_taken && (count_q < DEPTH);
    imem_addr   = pc_q;
    instr_valid = !reset && (count_q != 2'd0);
  end

  // A redirect flushes everything: the in-flight response and any pop are ignored.
  assign push = (state_q == S_WAIT) && imem_rvalid && !branch_taken;
  assign pop  = instr_valid && decode_ready && !branch_taken;

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    if (branch_taken) begin
      pc_d    = branch_target & ~64'h3;
      count_d = 2'd0;
    end else begin
      if (imem_req) begin
        pc_d     = pc_q + 64'd4;
        req_pc_d = pc_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= 64'h0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      if (branch_taken) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_q ^ pop;
        wr_ptr_q <= wr_ptr_q ^ push;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
      buf_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign instruction  = buf_instr_q[rd_ptr_q];
  assign instr_pc     = buf_pc_q[rd_ptr_q];
  assign instr_opcode = instruction[6:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_unit: directed + random stimulus against a queue model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  localparam logic [63:0] C_RESET_PC = 64'h0000_0000_2000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        instr_valid;
  logic        decode_ready;
  logic [31:0] instruction;
  logic [6:0]  instr_opcode;
  logic [63:0] instr_pc;

  instr_fetch_unit #(.RESET_PC(C_RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .decode_ready(decode_ready),
    .instruction(instruction), .instr_opcode(instr_opcode), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: queue of {pc, word}, plus "a request is in flight" and "its answer is unwanted".
  logic [95:0] q[$];
  logic [63:0] m_pc;
  logic [63:0] m_req_addr;
  bit          m_out;
  bit          m_drop;

  bit          mem_busy;
  int          mem_wait;
  int          lat_max;
  logic [31:0] mem_data;
  bit          force_en;
  logic [31:0] force_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit br, input logic [63:0] tgt, input bit dr,
                      input bit spur_ok);
    bit          exp_req;
    bit          exp_valid;
    logic [95:0] head;
    @(negedge clk);
    reset         = rst;
    branch_taken  = br;
    branch_target = tgt;
    decode_ready  = dr;
    imem_rvalid   = 1'b0;
    imem_rdata    = $urandom;
    if (mem_busy) begin
      if (mem_wait <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
        mem_busy    = 1'b0;
      end else begin
        mem_wait--;
      end
    end else if (spur_ok && $urandom_range(0, 15) == 0) begin
      imem_rvalid = 1'b1;
    end
    #1;
    exp_req   = !rst && !m_out && (q.size() < 2) && !br;
    exp_valid = !rst && (q.size() != 0);
    chk("imem_req", {63'b0, imem_req}, {63'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {63'b0, instr_valid}, {63'b0, exp_valid});
    if (exp_valid) begin
      head = q[0];
      chk("instr_pc", instr_pc, head[95:32]);
      chk("instruction", {32'b0, instruction}, {32'b0, head[31:0]});
      chk("instr_opcode", {57'b0, instr_opcode}, {57'b0, head[6:0]});
    end
    if (rst) begin
      q.delete();
      m_pc   = C_RESET_PC;
      m_out  = 1'b0;
      m_drop = 1'b0;
    end else if (br) begin
      q.delete();
      m_pc = {tgt[63:2], 2'b00};
      if (m_out) begin
        if (imem_rvalid) begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else begin
          m_drop = 1'b1;
        end
      end
    end else begin
      if (exp_valid && dr) void'(q.pop_front());
      if (m_out && imem_rvalid) begin
        if (!m_drop) q.push_back({m_req_addr, imem_rdata});
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if (exp_req) begin
        m_out      = 1'b1;
        m_drop     = 1'b0;
        m_req_addr = m_pc;
        m_pc       = m_pc + 64'd4;
        mem_busy   = 1'b1;
        mem_wait   = $urandom_range(1, lat_max);
        mem_data   = force_en ? force_data : $urandom;
      end
    end
  endtask

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_target = '0; decode_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    m_pc = C_RESET_PC; m_req_addr = '0; m_out = 1'b0; m_drop = 1'b0;
    mem_busy = 1'b0; mem_wait = 0; lat_max = 1; mem_data = '0;
    force_en = 1'b0; force_data = '0;

    repeat (2) step(1, 0, '0, 1, 0);
    repeat (8) step(0, 0, '0, 1, 0);              // streaming, one-cycle memory
    repeat (8) step(0, 0, '0, 0, 0);              // decode stalled: buffer fills
    repeat (6) step(0, 0, '0, 1, 0);
    step(0, 1, 64'h100, 1, 0);
    repeat (3) step(0, 0, '0, 1, 0);
    step(0, 1, 64'h103, 1, 0);                    // unaligned target
    repeat (4) step(0, 0, '0, 1, 0);
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);    // wrap-around
    repeat (6) step(0, 0, '0, 1, 0);
    lat_max = 3;
    step(0, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);                         // reset with a request in flight
    repeat (6) step(0, 0, '0, 1, 1);
    force_en = 1'b1; force_data = 32'h00A30333;
    repeat (6) step(0, 0, '0, 1, 0);
    force_en = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      logic [63:0] tgt;
      if (i % 500 == 0) lat_max = $urandom_range(1, 4);
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | {60'b0, tgt[3:0]};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0), tgt,
           ($urandom_range(0, 3) != 0), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, meaning the fetch buffer entry count; only the value 2 is supported.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 Port imem_req  output  1  SHALL be a one-cycle instruction-memory read request strobe.
REQ-006 Port imem_addr  output  64  SHALL carry the request address, valid when imem_req=1.
REQ-007 Port imem_rvalid  input  1  is the memory response strobe, one per request, arriving 1 or more cycles after the request.
REQ-008 Port imem_rdata  input  32  is the instruction word, valid when imem_rvalid=1.
REQ-009 Port branch_taken  input  1  is the one-cycle redirect pulse from the execute stage.
REQ-010 Port branch_target  input  64  is the redirect address, sampled when branch_taken=1.
REQ-011 Port instr_valid  output  1  SHALL be high when the buffer head holds an instruction for decode.
REQ-012 Port decode_ready  input  1  means decode accepts the head this cycle.
REQ-013 Port instruction  output  32  SHALL carry the head instruction word.
REQ-014 Port instr_opcode  output  7  SHALL equal instruction[6:0] and feeds the control unit Opcode input.
REQ-015 Port instr_pc  output  64  SHALL carry the fetch address of the head instruction.

Function
REQ-016 States SHALL be IDLE, WAIT and DROP, with at most one memory request outstanding.
REQ-017 In IDLE, imem_req SHALL be driven combinationally high with imem_addr=pc when buffer occupancy is less than 2 and branch_taken=0; the block SHALL then move to WAIT and set pc=pc+4, with 64-bit wrap-around.
REQ-018 In WAIT, on imem_rvalid=1 the block SHALL push {req_pc, imem_rdata} into the buffer and return to IDLE; req_pc is the address latched at request time.
REQ-019 In DROP, on imem_rvalid=1 the block SHALL discard the data and return to IDLE; no push SHALL occur.
REQ-020 imem_rvalid seen in IDLE SHALL be ignored.
REQ-021 The buffer SHALL be a 2-entry in-order FIFO; a pop SHALL occur when instr_valid=1 and decode_ready=1.
REQ-022 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-023 Data pushed in cycle N SHALL appear at the head in cycle N+1; with one-cycle memory latency the request-to-instr_valid latency SHALL be 2 cycles and peak throughput SHALL be one instruction per 2 cycles.
REQ-024 On branch_taken=1, the next cycle SHALL have an empty buffer, instr_valid=0, and pc={branch_target[63:2],2'b00}; any pop in that cycle SHALL be ignored.
REQ-025 branch_taken=1 in WAIT SHALL move the block to DROP; if imem_rvalid=1 in the same cycle, the response SHALL be discarded and the block SHALL move to IDLE.
REQ-026 branch_taken=1 in DROP SHALL keep the block in DROP, or move it to IDLE if imem_rvalid=1 in the same cycle, and SHALL update pc.
REQ-027 branch_taken=1 in IDLE SHALL suppress imem_req that cycle and keep the block in IDLE.
REQ-028 When the buffer is full, no request SHALL issue; instr_valid SHALL stay high and the head SHALL stay stable until popped.

Reset
REQ-029 While reset=1, the block SHALL set state=IDLE, pc=RESET_PC, occupancy=0 and req_pc=0, and SHALL hold imem_req=0 and instr_valid=0 regardless of other inputs.
REQ-030 reset asserted mid-WAIT SHALL abandon the outstanding request; a late imem_rvalid after reset SHALL be ignored because the block is in IDLE.
REQ-031 The first request after reset release SHALL issue in the first cycle with reset=0, with imem_addr=RESET_PC.

Verification
REQ-032 Reset release, memory with 1-cycle latency, decode_ready=1 -> requests to 0x0, 0x4 and 0x8 on alternate cycles; instructions appear with instr_pc 0x0, 0x4, 0x8 in order, each 2 cycles after its request.
REQ-033 decode_ready=0 -> exactly 2 instructions buffered, imem_req stays 0, head holds pc 0x0; raising decode_ready -> heads 0x0 then 0x4, then fetching resumes at 0x8.
REQ-034 branch_taken=1 with target 0x100 while in WAIT for 0x8 -> response for 0x8 dropped and buffer empty; next request goes to 0x100.
REQ-035 branch_taken=1 in the same cycle as imem_rvalid -> no push; next request goes to the target; target 0x103 -> request goes to 0x100.
REQ-036 pc=64'hFFFF_FFFF_FFFF_FFFC -> next request goes to 0x0; reset pulsed mid-WAIT followed by a late imem_rvalid -> no instr_valid, and the next request goes to RESET_PC.
REQ-037 imem_rdata=32'h00A30333 popped -> instr_opcode=7'b0110011.
